// File: rtl/mips_trace_pkg.sv
// Shared types, state encodings and helpers for the MIPS execution trace buffer.
// A trace entry is {tick, trace_payload_t}, i.e. TICK_W + 134 bits.
package mips_trace_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int PAYLOAD_W = 134;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] next_pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } trace_payload_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_trace_fifo.sv
// Trace entry storage: power-of-two ring buffer with first-word-fall-through head,
// occupancy count, and either drop-on-full (WRAP=0) or overwrite-oldest (WRAP=1).
module mips_trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 150,
    parameter int WRAP  = 0,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop_ready,
    output logic          out_valid,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          do_pop;
    logic          wr_en;
    logic          rd_adv;
    logic          ovf_set;

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign rdata     = mem[rd_ptr];
    assign do_pop    = out_valid && pop_ready;

    // Full with a pop frees the head slot; full without one either drops or,
    // under WRAP, overwrites the oldest entry and drags rd_ptr along.
    assign wr_en   = push && (!full || do_pop || (WRAP != 0));
    assign rd_adv  = do_pop || (push && full && (WRAP != 0));
    assign ovf_set = push && full && !do_pop;

    always_ff @(posedge CLK) begin
        if (!reset && !clear && wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_adv};
            if (ovf_set) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/mips_trace_buffer.sv
// Per-cycle MIPS execution trace capture: IDLE/RUN/DONE window FSM, tick stamp,
// optional register-write filter (macro MIPS_TRACE_FILTER_EN), FIFO drained by valid/ready.
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int TICK_W    = 16,
    parameter int MAX_TICKS = 8,
    parameter int WRAP      = 0,
    parameter int FILT_LO   = 16,
    parameter int FILT_HI   = 23
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_next_pc,
    input  logic                     in_we,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TICK_W-1:0]        out_tick,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_next_pc,
    output logic                     out_we,
    output logic [4:0]               out_rd,
    output logic [31:0]              out_wdata,
    output logic [clog2(DEPTH):0]    count,
    output logic                     running,
    output logic                     done,
    output logic                     overflow,
    output logic [1:0]               dbg_state
);

    localparam int          ENTRY_W   = TICK_W + PAYLOAD_W;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(MAX_TICKS - 1);

    // Handshake: the head entry transfers on any cycle where out_valid && out_ready;
    // out_valid never depends on out_ready, and head data holds until popped.

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_TICKS < 1 ||
        FILT_LO > FILT_HI || FILT_LO < 0 || FILT_HI > 31) begin : g_bad_params
        $error("mips_trace_buffer: illegal parameter combination");
    end

    logic [1:0]          state;
    logic [TICK_W-1:0]   tick;
    logic                accept;
    logic                push;
    trace_payload_t      in_pl;
    trace_payload_t      head_pl;
    logic [ENTRY_W-1:0]  head;

`ifdef MIPS_TRACE_FILTER_EN
    assign accept = in_valid && in_we && (32'(in_rd) >= FILT_LO) && (32'(in_rd) <= FILT_HI);
`else
    assign accept = in_valid;
`endif

    assign push = (state == RUN) && accept;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
            tick  <= '0;
        end else begin
            case (state)
                IDLE: if (arm) begin
                    state <= RUN;
                    tick  <= '0;
                end
                RUN: begin
                    tick <= tick + 1'b1;
                    if (tick == LAST_TICK) state <= DONE;
                end
                DONE: if (arm) begin
                    state <= RUN;
                    tick  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_pl = '{pc: in_pc, instr: in_instr, next_pc: in_next_pc,
                     we: in_we, rd: in_rd, wdata: in_wdata};

    mips_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .WRAP  (WRAP)
    ) u_fifo (
        .CLK       (CLK),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .wdata     ({tick, in_pl}),
        .pop_ready (out_ready),
        .out_valid (out_valid),
        .rdata     (head),
        .count     (count),
        .overflow  (overflow)
    );

    assign head_pl     = trace_payload_t'(head[PAYLOAD_W-1:0]);
    assign out_tick    = head[ENTRY_W-1:PAYLOAD_W];
    assign out_pc      = head_pl.pc;
    assign out_instr   = head_pl.instr;
    assign out_next_pc = head_pl.next_pc;
    assign out_we      = head_pl.we;
    assign out_rd      = head_pl.rd;
    assign out_wdata   = head_pl.wdata;

    assign running   = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: three instances (DEPTH16/WRAP0, DEPTH4/WRAP0,
// DEPTH4/WRAP1) share stimulus; each has its own out_ready and outputs.
module tb_mips_trace_buffer;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_next_pc = '0;
    logic        in_we = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_wdata = '0;
    logic        rdy [3];

    logic        ov  [3];
    logic [15:0] otk [3];
    logic [31:0] opc [3];
    logic [31:0] oin [3];
    logic [31:0] onp [3];
    logic        owe [3];
    logic [4:0]  ord [3];
    logic [31:0] owd [3];
    logic        run [3];
    logic        dn  [3];
    logic        ovf [3];
    logic [1:0]  st  [3];
    logic [4:0]  c0;
    logic [2:0]  c1;
    logic [2:0]  c2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [47:0] exp_q[$];

    always #5 CLK = ~CLK;

    mips_trace_buffer #(.DEPTH(16), .MAX_TICKS(8), .WRAP(0)) u0 (
        .CLK(CLK), .reset(reset), .arm(arm), .clear(clear), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr(in_instr), .in_next_pc(in_next_pc), .in_we(in_we),
        .in_rd(in_rd), .in_wdata(in_wdata), .out_valid(ov[0]), .out_ready(rdy[0]),
        .out_tick(otk[0]), .out_pc(opc[0]), .out_instr(oin[0]), .out_next_pc(onp[0]),
        .out_we(owe[0]), .out_rd(ord[0]), .out_wdata(owd[0]), .count(c0),
        .running(run[0]), .done(dn[0]), .overflow(ovf[0]), .dbg_state(st[0]));

    mips_trace_buffer #(.DEPTH(4), .MAX_TICKS(100), .WRAP(0)) u1 (
        .CLK(CLK), .reset(reset), .arm(arm), .clear(clear), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr(in_instr), .in_next_pc(in_next_pc), .in_we(in_we),
        .in_rd(in_rd), .in_wdata(in_wdata), .out_valid(ov[1]), .out_ready(rdy[1]),
        .out_tick(otk[1]), .out_pc(opc[1]), .out_instr(oin[1]), .out_next_pc(onp[1]),
        .out_we(owe[1]), .out_rd(ord[1]), .out_wdata(owd[1]), .count(c1),
        .running(run[1]), .done(dn[1]), .overflow(ovf[1]), .dbg_state(st[1]));

    mips_trace_buffer #(.DEPTH(4), .MAX_TICKS(100), .WRAP(1)) u2 (
        .CLK(CLK), .reset(reset), .arm(arm), .clear(clear), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr(in_instr), .in_next_pc(in_next_pc), .in_we(in_we),
        .in_rd(in_rd), .in_wdata(in_wdata), .out_valid(ov[2]), .out_ready(rdy[2]),
        .out_tick(otk[2]), .out_pc(opc[2]), .out_instr(oin[2]), .out_next_pc(onp[2]),
        .out_we(owe[2]), .out_rd(ord[2]), .out_wdata(owd[2]), .count(c2),
        .running(run[2]), .done(dn[2]), .overflow(ovf[2]), .dbg_state(st[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic we,
                         input logic [4:0] rd, input logic [31:0] wd);
        in_valid   = v;
        in_pc      = pc;
        in_instr   = {16'h2008, pc[15:0]};
        in_next_pc = pc + 32'd4;
        in_we      = we;
        in_rd      = rd;
        in_wdata   = wd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    initial begin
        logic [47:0] e;
        logic [4:0]  rds [4];
        rds = '{5'd8, 5'd16, 5'd23, 5'd24};
        for (int i = 0; i < 3; i++) rdy[i] = 1'b0;

        // Reset state
        do_reset();
        check("rst_count", c0, 0);
        check("rst_valid", ov[0], 0);
        check("rst_running", run[0], 0);
        check("rst_done", dn[0], 0);
        check("rst_overflow", ovf[0], 0);
        check("rst_state", st[0], 0);

        // Capture window of 8 ticks, 10 retired instructions offered
        arm_pulse();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, BASE + 32'(4 * i), 1'b0, '0, '0);
            if (i < 8) exp_q.push_back({16'(i), BASE + 32'(4 * i)});
            step();
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        check("win_count", c0, 8);
        check("win_done", dn[0], 1);
        check("win_running", run[0], 0);
        check("win_overflow", ovf[0], 0);
        check("win_state", st[0], 2);
        rdy[0] = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("win_head_valid", ov[0], 1);
            check("win_head_tick_pc", {otk[0], opc[0]}, e);
            check("win_head_next_pc", onp[0], e[31:0] + 32'd4);
            step();
        end
        rdy[0] = 1'b0;
        check("win_drained", c0, 0);
        check("win_empty_valid", ov[0], 0);

        // Six pushes into DEPTH=4: drop (u1) vs overwrite (u2)
        do_reset();
        arm_pulse();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, BASE + 32'(4 * i), 1'b0, '0, '0);
            step();
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        check("drop_count", c1, 4);
        check("drop_overflow", ovf[1], 1);
        check("wrap_count", c2, 4);
        check("wrap_overflow", ovf[2], 1);
        rdy[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drop_pc", opc[1], BASE + 32'(4 * k));
            step();
        end
        rdy[1] = 1'b0;
        check("drop_drained", c1, 0);
        rdy[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("wrap_tick", otk[2], 16'(2 + k));
            check("wrap_pc", opc[2], BASE + 32'(4 * (2 + k)));
            step();
        end
        rdy[2] = 1'b0;
        check("wrap_drained", c2, 0);

        // clear with a push in the same cycle discards the push and overflow
        clear = 1'b1;
        drive(1'b1, 32'h0000_dead, 1'b0, '0, '0);
        step();
        clear = 1'b0;
        drive(1'b0, '0, 1'b0, '0, '0);
        check("clr_count", c1, 0);
        check("clr_overflow", ovf[1], 0);
        check("clr_running", run[1], 1);

        // Full FIFO, WRAP=0, push with simultaneous pop
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, BASE + 32'h100 + 32'(4 * k), 1'b0, '0, '0);
            step();
        end
        drive(1'b1, BASE + 32'h200, 1'b0, '0, '0);
        rdy[1] = 1'b1;
        step();
        rdy[1] = 1'b0;
        drive(1'b0, '0, 1'b0, '0, '0);
        check("fullpop_count", c1, 4);
        check("fullpop_overflow", ovf[1], 0);
        rdy[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("fullpop_pc", opc[1], (k == 3) ? BASE + 32'h200 : BASE + 32'h104 + 32'(4 * k));
            step();
        end
        rdy[1] = 1'b0;

        // Register-write filter
        do_reset();
        arm_pulse();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, BASE + 32'(4 * i), 1'b1, rds[i], 32'hA000_0000 + 32'(rds[i]));
            step();
        end
        drive(1'b0, '0, 1'b0, '0, '0);
`ifdef MIPS_TRACE_FILTER_EN
        check("filt_count", c0, 2);
        rdy[0] = 1'b1;
        for (int k = 1; k < 3; k++) begin
            check("filt_tick", otk[0], 16'(k));
            check("filt_rd", ord[0], rds[k]);
            check("filt_wdata", owd[0], 32'hA000_0000 + 32'(rds[k]));
            step();
        end
`else
        check("nofilt_count", c0, 4);
        rdy[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("nofilt_rd", ord[0], rds[k]);
            check("nofilt_wdata", owd[0], 32'hA000_0000 + 32'(rds[k]));
            check("nofilt_we", owe[0], 1);
            step();
        end
`endif
        rdy[0] = 1'b0;
        check("filt_drained", c0, 0);

        // Reset mid-capture, pop on empty, then restart at tick 0
        do_reset();
        arm_pulse();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, BASE + 32'(4 * i), 1'b0, '0, '0);
            step();
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        check("mid_count", c0, 3);
        check("mid_running", run[0], 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_count", c0, 0);
        check("mid_rst_running", run[0], 0);
        check("mid_rst_valid", ov[0], 0);
        check("mid_rst_state", st[0], 0);
        rdy[0] = 1'b1;
        step();
        rdy[0] = 1'b0;
        check("empty_pop_count", c0, 0);
        arm_pulse();
        drive(1'b1, BASE + 32'h40, 1'b0, '0, '0);
        step();
        drive(1'b0, '0, 1'b0, '0, '0);
        check("rearm_count", c0, 1);
        check("rearm_tick", otk[0], 0);
        check("rearm_pc", opc[0], BASE + 32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
